// File: rtl/store_buffer_pkg.sv
// Shared constants and the buffered-store entry layout for the store buffer.
package store_buffer_pkg;

  localparam int unsigned STORE_BUFFER_DEPTH      = 4;
  localparam int unsigned STORE_BUFFER_ADDR_WIDTH = 32;
  localparam int unsigned STORE_BUFFER_DATA_WIDTH = 32;
  localparam int unsigned STORE_BUFFER_BE_WIDTH   = STORE_BUFFER_DATA_WIDTH / 8;

  // Field widths are the ceiling for the module parameters; narrower
  // instances cast into and out of these fields.
  typedef struct packed {
    logic [STORE_BUFFER_ADDR_WIDTH-1:0] address;
    logic [STORE_BUFFER_DATA_WIDTH-1:0] data;
    logic [STORE_BUFFER_BE_WIDTH-1:0]   byteEnable;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Memory-stage / data-memory facing signals of the store buffer.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = STORE_BUFFER_DEPTH,
  parameter int unsigned ADDR_WIDTH = STORE_BUFFER_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = STORE_BUFFER_DATA_WIDTH
);
  localparam int unsigned BE_WIDTH    = DATA_WIDTH / 8;
  localparam int unsigned COUNT_WIDTH = $clog2(DEPTH) + 1;

  logic                   enqueueValid;
  logic [ADDR_WIDTH-1:0]  enqueueAddress;
  logic [DATA_WIDTH-1:0]  enqueueData;
  logic [BE_WIDTH-1:0]    enqueueByteEnable;
  logic                   enqueueReady;

  logic                   loadCheckValid;
  logic [ADDR_WIDTH-1:0]  loadCheckAddress;
  logic [BE_WIDTH-1:0]    loadCheckByteEnable;
  logic                   loadForwardValid;
  logic [DATA_WIDTH-1:0]  loadForwardData;
  logic                   loadConflict;

  logic                   storeValid;
  logic [ADDR_WIDTH-1:0]  addressRegister;
  logic [DATA_WIDTH-1:0]  storeData;
  logic [BE_WIDTH-1:0]    realStoreByteEnable;
  logic                   storeComplete;

  logic [COUNT_WIDTH-1:0] count;
  logic                   empty;

  modport slave (
    input  enqueueValid, enqueueAddress, enqueueData, enqueueByteEnable,
    output enqueueReady,
    input  loadCheckValid, loadCheckAddress, loadCheckByteEnable,
    output loadForwardValid, loadForwardData, loadConflict,
    output storeValid, addressRegister, storeData, realStoreByteEnable,
    input  storeComplete,
    output count, empty
  );

  modport master (
    output enqueueValid, enqueueAddress, enqueueData, enqueueByteEnable,
    input  enqueueReady,
    output loadCheckValid, loadCheckAddress, loadCheckByteEnable,
    input  loadForwardValid, loadForwardData, loadConflict,
    input  storeValid, addressRegister, storeData, realStoreByteEnable,
    output storeComplete,
    input  count, empty
  );

endinterface

// File: rtl/store_buffer_match.sv
// Combinational youngest-match finder: scans occupied slots oldest to youngest
// so the last word-address hit wins, then reports whether it covers the load lanes.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = STORE_BUFFER_DEPTH,
  parameter int unsigned WORD_WIDTH = 30,
  parameter int unsigned BE_WIDTH   = STORE_BUFFER_BE_WIDTH
) (
  input  logic [DEPTH-1:0][WORD_WIDTH-1:0] entryWord,
  input  logic [DEPTH-1:0][BE_WIDTH-1:0]   entryByteEnable,
  input  logic [$clog2(DEPTH)-1:0]         head,
  input  logic [$clog2(DEPTH):0]           occupancy,
  input  logic [WORD_WIDTH-1:0]            queryWord,
  input  logic [BE_WIDTH-1:0]              queryByteEnable,
  output logic                             hit,
  output logic [$clog2(DEPTH)-1:0]         index,
  output logic                             covered
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] slot;

  always_comb begin
    hit     = 1'b0;
    index   = head;
    slot    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if (k < 32'(occupancy) && entryWord[slot] == queryWord) begin
        hit   = 1'b1;
        index = slot;
      end
    end
    covered = hit && ((entryByteEnable[index] & queryByteEnable) == queryByteEnable);
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between the memory stage and data memory, with
// zero-latency single-entry load forwarding and conflict detection.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = STORE_BUFFER_DEPTH,
  parameter int unsigned ADDR_WIDTH = STORE_BUFFER_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = STORE_BUFFER_DATA_WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  store_buffer_if.slave sb
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned LANE_W   = $clog2(BE_WIDTH);
  localparam int unsigned WORD_W   = ADDR_WIDTH - LANE_W;

  sb_entry_t          entries [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count_q;
  logic               do_enq;
  logic               do_pop;

  logic [DEPTH-1:0][WORD_W-1:0]   entryWord;
  logic [DEPTH-1:0][BE_WIDTH-1:0] entryBe;
  logic                           matchHit;
  logic [PTR_W-1:0]               matchIndex;
  logic                           matchCovered;

  assign sb.enqueueReady = (count_q != CNT_W'(DEPTH));
  assign sb.empty        = (count_q == '0);
  assign sb.storeValid   = !sb.empty;
  assign sb.count        = count_q;

  assign do_enq = sb.enqueueValid && sb.enqueueReady;
  assign do_pop = sb.storeValid && sb.storeComplete;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (do_enq) tail <= tail + 1'b1;
      if (do_pop) head <= head + 1'b1;
      case ({do_enq, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload is deliberately not reset; occupancy alone decides validity.
  always_ff @(posedge clock) begin
    if (do_enq) begin
      entries[tail] <= '{
        address:    STORE_BUFFER_ADDR_WIDTH'(sb.enqueueAddress),
        data:       STORE_BUFFER_DATA_WIDTH'(sb.enqueueData),
        byteEnable: STORE_BUFFER_BE_WIDTH'(sb.enqueueByteEnable)
      };
    end
  end

  assign sb.addressRegister     = ADDR_WIDTH'(entries[head].address);
  assign sb.storeData           = DATA_WIDTH'(entries[head].data);
  assign sb.realStoreByteEnable = BE_WIDTH'(entries[head].byteEnable);

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry_view
    assign entryWord[i] = entries[i].address[ADDR_WIDTH-1:LANE_W];
    assign entryBe[i]   = BE_WIDTH'(entries[i].byteEnable);
  end

  store_buffer_match #(
    .DEPTH      (DEPTH),
    .WORD_WIDTH (WORD_W),
    .BE_WIDTH   (BE_WIDTH)
  ) u_match (
    .entryWord       (entryWord),
    .entryByteEnable (entryBe),
    .head            (head),
    .occupancy       (count_q),
    .queryWord       (sb.loadCheckAddress[ADDR_WIDTH-1:LANE_W]),
    .queryByteEnable (sb.loadCheckByteEnable),
    .hit             (matchHit),
    .index           (matchIndex),
    .covered         (matchCovered)
  );

  // A store entering this cycle is invisible to the matcher, so a concurrent
  // load must stall rather than risk reading stale memory.
  always_comb begin
    sb.loadForwardValid = 1'b0;
    sb.loadConflict     = 1'b0;
    sb.loadForwardData  = '0;
    if (sb.loadCheckValid) begin
      if (sb.enqueueValid) begin
        sb.loadConflict = 1'b1;
      end else if (matchHit) begin
        if (matchCovered) begin
          sb.loadForwardValid = 1'b1;
          sb.loadForwardData  = DATA_WIDTH'(entries[matchIndex].data);
        end else begin
          sb.loadConflict = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: queue-based reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic clock;
  logic reset;

  store_buffer_if #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .sb    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } st_t;

  st_t q[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of stores.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      automatic bit pop = (q.size() != 0) && bus.storeComplete;
      automatic bit enq = bus.enqueueValid && (q.size() < DEPTH);
      if (pop) void'(q.pop_front());
      if (enq) q.push_back('{bus.enqueueAddress, bus.enqueueData, bus.enqueueByteEnable});
    end
  end

  function automatic void expect_fwd(output logic fv, output logic cf, output logic [31:0] fd);
    fv = 1'b0; cf = 1'b0; fd = '0;
    if (bus.loadCheckValid) begin
      if (bus.enqueueValid) begin
        cf = 1'b1;
      end else begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].addr[31:2] == bus.loadCheckAddress[31:2]) begin
            if ((q[i].be & bus.loadCheckByteEnable) == bus.loadCheckByteEnable) begin
              fv = 1'b1;
              fd = q[i].data;
            end else begin
              cf = 1'b1;
            end
            break;
          end
        end
      end
    end
  endfunction

  always @(negedge clock) begin
    logic        fv, cf;
    logic [31:0] fd;
    expect_fwd(fv, cf, fd);
    check("m_enqueueReady", 64'(bus.enqueueReady), 64'(q.size() < DEPTH));
    check("m_storeValid", 64'(bus.storeValid), 64'(q.size() != 0));
    check("m_empty", 64'(bus.empty), 64'(q.size() == 0));
    check("m_count", 64'(bus.count), 64'(q.size()));
    check("m_loadForwardValid", 64'(bus.loadForwardValid), 64'(fv));
    check("m_loadConflict", 64'(bus.loadConflict), 64'(cf));
    check("m_loadForwardData", 64'(bus.loadForwardData), 64'(fd));
    if (q.size() != 0) begin
      check("m_addressRegister", 64'(bus.addressRegister), 64'(q[0].addr));
      check("m_storeData", 64'(bus.storeData), 64'(q[0].data));
      check("m_realStoreByteEnable", 64'(bus.realStoreByteEnable), 64'(q[0].be));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.enqueueValid      = 1'b1;
    bus.enqueueAddress    = a;
    bus.enqueueData       = d;
    bus.enqueueByteEnable = be;
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] be);
    bus.loadCheckValid      = 1'b1;
    bus.loadCheckAddress    = a;
    bus.loadCheckByteEnable = be;
  endtask

  initial begin
    int popIdx;
    reset = 1'b1;
    bus.enqueueValid = 1'b0; bus.enqueueAddress = '0; bus.enqueueData = '0;
    bus.enqueueByteEnable = '0; bus.loadCheckValid = 1'b0; bus.loadCheckAddress = '0;
    bus.loadCheckByteEnable = '0; bus.storeComplete = 1'b0;
    tick(); settle();
    check("rst_storeValid", 64'(bus.storeValid), 64'(0));
    check("rst_empty", 64'(bus.empty), 64'(1));
    check("rst_ready", 64'(bus.enqueueReady), 64'(1));
    check("rst_count", 64'(bus.count), 64'(0));
    tick(); reset = 1'b0;

    // stray storeComplete on an empty buffer
    bus.storeComplete = 1'b1; tick(); bus.storeComplete = 1'b0;

    // single store held while memory is busy
    enq(32'h100, 32'hAABBCCDD, 4'b1111); settle();
    check("enq_cycle_storeValid", 64'(bus.storeValid), 64'(0));
    tick(); bus.enqueueValid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("hold_storeValid", 64'(bus.storeValid), 64'(1));
      check("hold_addr", 64'(bus.addressRegister), 64'(32'h100));
      check("hold_data", 64'(bus.storeData), 64'(32'hAABBCCDD));
      check("hold_be", 64'(bus.realStoreByteEnable), 64'(4'b1111));
      check("hold_count", 64'(bus.count), 64'(1));
      tick();
    end
    bus.storeComplete = 1'b1; tick(); bus.storeComplete = 1'b0; settle();
    check("drain1_empty", 64'(bus.empty), 64'(1));
    tick();

    // fill, overflow attempt, pop while full
    for (int i = 0; i < 4; i++) begin
      enq(32'(32'h400 + 4 * i), 32'(32'h1000 + i), 4'b1111); tick();
    end
    bus.enqueueValid = 1'b0; settle();
    check("full_ready", 64'(bus.enqueueReady), 64'(0));
    check("full_count", 64'(bus.count), 64'(4));
    tick();
    enq(32'h500, 32'h00000BAD, 4'b1111); tick(); settle();
    check("full_ignored_count", 64'(bus.count), 64'(4));
    check("full_head", 64'(bus.addressRegister), 64'(32'h400));
    bus.storeComplete = 1'b1; tick();
    bus.enqueueValid = 1'b0; bus.storeComplete = 1'b0; settle();
    check("afterpop_count", 64'(bus.count), 64'(3));
    check("afterpop_ready", 64'(bus.enqueueReady), 64'(1));
    check("afterpop_head", 64'(bus.addressRegister), 64'(32'h404));
    bus.storeComplete = 1'b1; repeat (3) tick(); bus.storeComplete = 1'b0; settle();
    check("drain2_empty", 64'(bus.empty), 64'(1));
    tick();

    // byte store forwarding
    enq(32'h203, 32'h11000000, 4'b1000); tick(); bus.enqueueValid = 1'b0;
    load(32'h203, 4'b1000); settle();
    check("sb_fwd_valid", 64'(bus.loadForwardValid), 64'(1));
    check("sb_fwd_byte3", 64'(bus.loadForwardData[31:24]), 64'(8'h11));
    check("sb_fwd_conflict", 64'(bus.loadConflict), 64'(0));
    tick();
    load(32'h200, 4'b0001); settle();
    check("sb_partial_conflict", 64'(bus.loadConflict), 64'(1));
    tick();
    bus.loadCheckValid = 1'b0; bus.storeComplete = 1'b1; tick(); bus.storeComplete = 1'b0;

    // youngest-only matching, no lane merge
    enq(32'h300, 32'hDEADBEEF, 4'b1111); tick();
    enq(32'h300, 32'h000000AA, 4'b0001); tick(); bus.enqueueValid = 1'b0;
    load(32'h300, 4'b0001); settle();
    check("young_fwd_data", 64'(bus.loadForwardData), 64'(32'h000000AA));
    tick();
    load(32'h300, 4'b1111); settle();
    check("nomerge_conflict0", 64'(bus.loadConflict), 64'(1));
    bus.storeComplete = 1'b1; tick(); settle();
    check("nomerge_conflict1", 64'(bus.loadConflict), 64'(1));
    tick(); bus.storeComplete = 1'b0; settle();
    check("nomerge_conflict2", 64'(bus.loadConflict), 64'(0));
    check("nomerge_fwd2", 64'(bus.loadForwardValid), 64'(0));
    tick(); bus.loadCheckValid = 1'b0;

    // load concurrent with enqueue stalls, then forwards
    enq(32'h700, 32'h12345678, 4'b1111); load(32'h700, 4'b1111); settle();
    check("concur_conflict", 64'(bus.loadConflict), 64'(1));
    check("concur_fwd", 64'(bus.loadForwardValid), 64'(0));
    tick(); bus.enqueueValid = 1'b0; settle();
    check("concur_count", 64'(bus.count), 64'(1));
    check("concur_fwd_data", 64'(bus.loadForwardData), 64'(32'h12345678));
    tick(); bus.loadCheckValid = 1'b0;
    bus.storeComplete = 1'b1; tick(); bus.storeComplete = 1'b0;

    // simultaneous enqueue/pop and pointer wrap over 8 stores
    enq(32'h600, 32'h0, 4'b1111); tick();
    enq(32'h604, 32'h1, 4'b1111); tick();
    enq(32'h608, 32'h2, 4'b1111); bus.storeComplete = 1'b1; settle();
    check("order_0", 64'(bus.addressRegister), 64'(32'h600));
    tick(); bus.enqueueValid = 1'b0; bus.storeComplete = 1'b0; settle();
    check("simul_count", 64'(bus.count), 64'(2));
    tick();
    popIdx = 1;
    for (int i = 3; i < 8; i++) begin
      enq(32'(32'h600 + 4 * i), 32'(i), 4'b1111); bus.storeComplete = 1'b1; settle();
      check("order", 64'(bus.addressRegister), 64'(32'(32'h600 + 4 * popIdx)));
      check("wrap_count", 64'(bus.count), 64'(2));
      popIdx++;
      tick();
    end
    bus.enqueueValid = 1'b0;
    repeat (2) begin
      settle();
      check("order_tail", 64'(bus.addressRegister), 64'(32'(32'h600 + 4 * popIdx)));
      popIdx++;
      tick();
    end
    bus.storeComplete = 1'b0; settle();
    check("wrap_empty", 64'(bus.empty), 64'(1));
    tick();

    // reset mid-drain
    for (int i = 0; i < 4; i++) begin
      enq(32'(32'h800 + 4 * i), 32'(32'hF0 + i), 4'b1111); tick();
    end
    bus.enqueueValid = 1'b0; bus.storeComplete = 1'b1; tick(); settle();
    check("middrain_count", 64'(bus.count), 64'(3));
    tick(); #1;
    reset = 1'b1; #1;
    check("rstmid_storeValid", 64'(bus.storeValid), 64'(0));
    check("rstmid_empty", 64'(bus.empty), 64'(1));
    check("rstmid_count", 64'(bus.count), 64'(0));
    tick(); reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("postrst_storeValid", 64'(bus.storeValid), 64'(0));
      tick();
    end
    bus.storeComplete = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
